// File: rtl/tt_um_lnl_soc.sv
// Load-and-Launch SoC: 8-bit accumulator CPU with a 32-byte unified memory that is loaded through the tile pins.
// Optional debug status on the bidirectional pins is enabled by defining LNL_DEBUG_EN.
module tt_um_lnl_soc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_JZ  = 3'b101;
    localparam logic [2:0] OP_OUT = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    state_t      state_q, state_d;
    logic [4:0]  pc_q, pc_d;
    logic [4:0]  wptr_q, wptr_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  acc_q, acc_d;
    logic        c_q, c_d;
    logic [7:0]  outr_q, outr_d;
    logic        strobe_prev_q, strobe_prev_d;
    logic [7:0]  mem_q [32];
    logic [7:0]  mem_d [32];

    logic [7:0]  operand;
    logic [8:0]  sum;
    logic        zero;
    logic        load_mode;
    logic        strobe_rise;
    logic        unused_bits;

    assign load_mode   = ui_in[7];
    assign strobe_rise = ui_in[6] & ~strobe_prev_q;
    assign operand     = mem_q[ir_q[4:0]];
    assign sum         = {1'b0, acc_q} + {1'b0, operand};
    assign zero        = (acc_q == 8'h00);
    assign unused_bits = &{1'b0, ui_in[5:0]};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        wptr_d        = wptr_q;
        ir_d          = ir_q;
        acc_d         = acc_q;
        c_d           = c_q;
        outr_d        = outr_q;
        strobe_prev_d = ui_in[6];
        mem_d         = mem_q;

        // LOAD mode overrides whatever the CPU was doing; only an already-LOAD state accepts writes.
        if (load_mode) begin
            state_d = ST_LOAD;
            pc_d    = 5'd0;
            if (state_q != ST_LOAD) begin
                wptr_d = 5'd0;
            end else if (strobe_rise) begin
                mem_d[wptr_q] = uio_in;
                wptr_d        = wptr_q + 5'd1;
            end
        end else begin
            case (state_q)
                ST_LOAD: begin
                    state_d = ST_FETCH;
                    pc_d    = 5'd0;
                end
                ST_FETCH: begin
                    ir_d    = mem_q[pc_q];
                    pc_d    = pc_q + 5'd1;
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    state_d = ST_FETCH;
                    case (ir_q[7:5])
                        OP_LDA: acc_d = operand;
                        OP_STA: mem_d[ir_q[4:0]] = acc_q;
                        OP_ADD: begin
                            acc_d = sum[7:0];
                            c_d   = sum[8];
                        end
                        OP_SUB: begin
                            acc_d = acc_q - operand;
                            c_d   = (acc_q < operand);
                        end
                        OP_JMP: pc_d = ir_q[4:0];
                        OP_JZ: begin
                            if (zero) begin
                                pc_d = ir_q[4:0];
                            end
                        end
                        OP_OUT: outr_d = acc_q;
                        OP_HLT: state_d = ST_HALT;
                        default: state_d = ST_HALT;
                    endcase
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            pc_q          <= 5'd0;
            wptr_q        <= 5'd0;
            ir_q          <= 8'h00;
            acc_q         <= 8'h00;
            c_q           <= 1'b0;
            outr_q        <= 8'h00;
            strobe_prev_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= 8'hFF;
            end
        end else if (ena) begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            wptr_q        <= wptr_d;
            ir_q          <= ir_d;
            acc_q         <= acc_d;
            c_q           <= c_d;
            outr_q        <= outr_d;
            strobe_prev_q <= strobe_prev_d;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign uo_out = outr_q;

`ifdef LNL_DEBUG_EN
    assign uio_out = {(state_q == ST_HALT), zero, c_q, pc_q};
    assign uio_oe  = (state_q == ST_LOAD) ? 8'h00 : 8'hFF;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_lnl_soc.sv
// Directed testbench for tt_um_lnl_soc: loads small programs through the pins and checks
// outputs and key architectural registers against hand-computed values.
module tb_tt_um_lnl_soc;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int assertCount;
    int failCount;

    logic [7:0] progImg [12];

    tt_um_lnl_soc dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Drive the pin inputs, then let one active edge consume them.
    task automatic applyStimulus(input logic [7:0] ui, input logic [7:0] data);
        ui_in  = ui;
        uio_in = data;
        tick(1);
    endtask

    // Checks the CPU-visible state while running or halted.
    task automatic checkRun(input string tag, input logic expHalt, input logic [7:0] expAcc,
                            input logic expC, input logic [4:0] expPc, input logic [7:0] expUo);
        logic [7:0] expDbg;
        logic [7:0] expOe;
`ifdef LNL_DEBUG_EN
        expDbg = {expHalt, (expAcc == 8'h00), expC, expPc};
        expOe  = 8'hFF;
`else
        expDbg = 8'h00;
        expOe  = 8'h00;
`endif
        checkOutput({tag, ".uo"},   uo_out, expUo);
        checkOutput({tag, ".acc"},  dut.acc_q, expAcc);
        checkOutput({tag, ".c"},    {7'd0, dut.c_q}, {7'd0, expC});
        checkOutput({tag, ".pc"},   {3'd0, dut.pc_q}, {3'd0, expPc});
        checkOutput({tag, ".halt"}, {7'd0, (dut.state_q == 2'd3)}, {7'd0, expHalt});
        checkOutput({tag, ".dbg"},  uio_out, expDbg);
        checkOutput({tag, ".oe"},   uio_oe, expOe);
    endtask

    // Enter LOAD, write progImg to addresses 0..11, and leave LOAD (state becomes FETCH).
    task automatic loadImage();
        logic [7:0] expOe;
        applyStimulus(8'h80, 8'h00);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'hC0, progImg[i]);
            applyStimulus(8'h80, progImg[i]);
        end
        expOe = 8'h00;
        checkOutput("load.state", {6'd0, dut.state_q}, 8'h00);
        checkOutput("load.oe", uio_oe, expOe);
        checkOutput("load.wptr", {3'd0, dut.wptr_q}, 8'd12);
        applyStimulus(8'h00, 8'h00);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset values.
        tick(2);
        checkRun("reset", 1'b0, 8'h00, 1'b0, 5'd0, 8'h00);
        checkOutput("reset.ir", dut.ir_q, 8'h00);
        checkOutput("reset.mem0", dut.mem_q[0], 8'hFF);
        checkOutput("reset.mem31", dut.mem_q[31], 8'hFF);
        checkOutput("reset.state", {6'd0, dut.state_q}, 8'h01);

        // Unloaded memory is all HLT: halted after two cycles with PC=1.
        rst_n = 1'b1;
        tick(1);
        checkRun("noload.c1", 1'b0, 8'h00, 1'b0, 5'd1, 8'h00);
        tick(1);
        checkRun("noload.c2", 1'b1, 8'h00, 1'b0, 5'd1, 8'h00);

        // LDA 8, ADD 9, OUT, HLT with 5+3.
        progImg = '{8'h08, 8'h49, 8'hC0, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h05, 8'h03, 8'h00, 8'h00};
        loadImage();
        tick(5);
        checkRun("add.c5", 1'b0, 8'h08, 1'b0, 5'd3, 8'h00);
        tick(1);
        checkRun("add.c6", 1'b0, 8'h08, 1'b0, 5'd3, 8'h08);
        tick(2);
        checkRun("add.c8", 1'b1, 8'h08, 1'b0, 5'd4, 8'h08);

        // Same program with 0xFF+0x02: wraps to 0x01 with carry.
        progImg[8] = 8'hFF;
        progImg[9] = 8'h02;
        loadImage();
        tick(8);
        checkRun("carry.c8", 1'b1, 8'h01, 1'b1, 5'd4, 8'h01);

        // Countdown loop: LDA 11, SUB 10, OUT, JZ 5, JMP 1, HLT.
        progImg = '{8'h0B, 8'h6A, 8'hC0, 8'hA5, 8'h81, 8'hE0, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h01, 8'h03};
        loadImage();
        tick(6);
        checkRun("loop.c6", 1'b0, 8'h02, 1'b0, 5'd3, 8'h02);
        tick(4);
        checkRun("loop.c10", 1'b0, 8'h02, 1'b0, 5'd1, 8'h02);

        // Freeze with ena low, including a strobe/load request that must be ignored.
        ena = 1'b0;
        applyStimulus(8'hC0, 8'h99);
        applyStimulus(8'h00, 8'h00);
        tick(3);
        checkRun("freeze", 1'b0, 8'h02, 1'b0, 5'd1, 8'h02);
        checkOutput("freeze.strobe", {7'd0, dut.strobe_prev_q}, 8'h00);
        ena = 1'b1;
        tick(4);
        checkRun("loop.c14", 1'b0, 8'h01, 1'b0, 5'd3, 8'h01);
        tick(8);
        checkRun("loop.c22", 1'b0, 8'h00, 1'b0, 5'd3, 8'h00);
        tick(2);
        checkRun("loop.c24", 1'b0, 8'h00, 1'b0, 5'd5, 8'h00);
        tick(2);
        checkRun("loop.c26", 1'b1, 8'h00, 1'b0, 5'd6, 8'h00);

        // Strobe held high for five cycles writes only once.
        applyStimulus(8'h80, 8'h00);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'hC0, 8'h10 + 8'(i));
        end
        applyStimulus(8'h80, 8'h00);
        checkOutput("hold.mem0", dut.mem_q[0], 8'h10);
        checkOutput("hold.mem1", dut.mem_q[1], 8'h6A);
        checkOutput("hold.wptr", {3'd0, dut.wptr_q}, 8'd1);

        // Strobe already high on the LOAD-entry edge is not a write.
        applyStimulus(8'h00, 8'h00);
        applyStimulus(8'hC0, 8'h77);
        applyStimulus(8'hC0, 8'h77);
        applyStimulus(8'h80, 8'h77);
        checkOutput("entry.mem0", dut.mem_q[0], 8'h10);
        applyStimulus(8'hC0, 8'h55);
        applyStimulus(8'h80, 8'h55);
        checkOutput("entry.write", dut.mem_q[0], 8'h55);

        // 33 strobes wrap the write pointer: address 0 holds the 33rd byte.
        applyStimulus(8'h00, 8'h00);
        applyStimulus(8'h80, 8'h00);
        for (int i = 0; i < 33; i++) begin
            applyStimulus(8'hC0, 8'h40 + 8'(i));
            applyStimulus(8'h80, 8'h00);
        end
        checkOutput("wrap.mem0", dut.mem_q[0], 8'h60);
        checkOutput("wrap.mem1", dut.mem_q[1], 8'h41);
        checkOutput("wrap.mem31", dut.mem_q[31], 8'h5F);
        checkOutput("wrap.wptr", {3'd0, dut.wptr_q}, 8'd1);

        // Asynchronous reset in the middle of the loop program.
        applyStimulus(8'h00, 8'h00);
        loadImage();
        tick(12);
        checkRun("midrun.c12", 1'b0, 8'h01, 1'b0, 5'd2, 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        checkRun("midrun.rst", 1'b0, 8'h00, 1'b0, 5'd0, 8'h00);
        checkOutput("midrun.ir", dut.ir_q, 8'h00);
        checkOutput("midrun.mem0", dut.mem_q[0], 8'hFF);
        checkOutput("midrun.mem11", dut.mem_q[11], 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        checkRun("midrun.halt", 1'b1, 8'h00, 1'b0, 5'd1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
